south_bridge_nx: RTL and testbench
==================================

Name: south_bridge_nx

Overview:
- Parametrised successor to the two-timer south bridge.
- Sits between the CPU's device-space port and NDEV memory-mapped devices: timers, UART, switches, and so on.
- Decodes the address into per-device windows and runs a registered req/ack handshake with wait states and a timeout.
- Owns an IRQ controller that conditions the device and external interrupt sources into the 6-bit HWInt vector for CP0 (IRQ[7:2]).

Parameters:
- NDEV, 2: number of device slots, 1..6.
- NEXT, 1: number of external IRQ inputs; NDEV+NEXT must not exceed 6.
- DEV_BASE, {32'h0000_7F10, 32'h0000_7F00}: packed NDEV*32 base addresses; slot i uses bits [32i+31:32i].
- DEV_AW, 2: word-offset bits per device window. The window is 2^(DEV_AW+2) bytes.
- CTRL_BASE, 32'h0000_7F80: base address of the bridge's own register window (2 words).
- TIMEOUT, 15: maximum wait cycles for dev_ack before a bus error.
- EDGE_MODE, 6'b000000: per-line mode. 1 = rising-edge latched, 0 = level.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held until cpu_ready.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_we  in  4  byte enables; 0 means read.
- cpu_rdata  out  32  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  bus error, qualified by cpu_ready.
- irq  out  6  HWInt[7:2] to CP0.
- dev_req  out  NDEV  one-hot request to the selected device.
- dev_addr  out  DEV_AW  shared word offset.
- dev_wdata  out  32  shared write data.
- dev_we  out  4  shared byte enables.
- dev_rdata  in  NDEV*32  packed per-device read data.
- dev_ack  in  NDEV  per-device acknowledge.
- dev_irq  in  NDEV  device interrupt lines.
- ext_irq  in  NEXT  external interrupt lines, asynchronous to clk.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, irq_mask=6'h3F, pending=0, sync flops=0.
- Decode: slot i hits when cpu_addr[31:DEV_AW+2]==DEV_BASE_i[31:DEV_AW+2]. The CTRL window hits on cpu_addr[31:3]==CTRL_BASE[31:3]. Overlapping windows are a config error; the lowest index wins.
- FSM states are IDLE, DEV, RESP.
  - IDLE -> DEV: cpu_req with a slot hit. Latch the index and register addr[DEV_AW+1:2], wdata and we onto dev_*. dev_req[idx]=1 from the next cycle.
  - IDLE -> RESP: CTRL hit, or no hit. A CTRL access is performed in this cycle. A miss sets err.
  - DEV -> RESP: dev_ack[idx]=1. Capture dev_rdata slot idx into cpu_rdata and drop dev_req. Acks from non-selected slots are ignored.
  - DEV -> RESP with err: the wait counter reaches TIMEOUT without an ack. cpu_rdata=0.
  - RESP -> IDLE: cpu_ready=1 for exactly this cycle; cpu_err as latched. A new request is accepted in the next IDLE cycle. There is no back-to-back acceptance in RESP.
- Latency:
  - Device access with zero wait: req seen cycle 0, dev_req cycle 1, ack in cycle 1, cpu_ready cycle 2.
  - Each wait cycle adds 1.
  - CTRL access or miss: cpu_ready in cycle 1.
- Wait counter: 4 bits minimum, cleared on DEV entry, saturating. An ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- cpu_rdata and cpu_err hold their last value outside RESP. Only cpu_ready qualifies them.
- IRQ sources: src[5:0] = {zeros, ext_irq, dev_irq}, with dev_irq in the LSBs.
  - ext_irq passes through a 2-flop synchroniser.
  - dev_irq is used directly.
- Level line: pending[i] = src[i], combinationally after sync.
- Edge line: pending[i] is set on a 0->1 change of src[i], registered against the previous-cycle value. It is cleared by a W1C write. A set in the same cycle as a clear wins.
- irq = pending & irq_mask, registered, so there is one cycle of latency from pending.
- CTRL registers:
  - Offset 0: IRQ_MASK, RW, bits [5:0].
  - Offset 4: IRQ_PEND, read pending, W1C on edge lines only.
  - Writes honour byte enable 0 only. Upper bits read 0.
- Reset mid-transaction: abort immediately. dev_req=0; no ready pulse is emitted.

Decomposition:
- Shared package/header: FSM state encodings, CTRL register offsets, default base addresses, and the HWInt width constant 6.
- One natural sub-module: irq_ctrl_nx, containing the synchronisers, edge detect, pending/mask registers and the irq register. The bridge FSM stays in the top level.

Test Plan:
1. Read slot 1 at 0x7F14, ack after 3 wait cycles, dev_rdata1=0xDEADBEEF -> dev_addr=1, dev_req=2'b10 for 4 cycles; cpu_ready at cycle 5 with rdata 0xDEADBEEF, err=0.
2. Write 0x7F00 with we=4'hF and an immediate ack -> dev_we=4'hF, dev_wdata matches, cpu_ready in cycle 2.
3. Access 0x7F40 (unmapped) -> cpu_ready+cpu_err in cycle 1, no dev_req. Slot 0 never acks -> err after TIMEOUT=15 wait cycles, rdata=0.
4. EDGE_MODE=6'b000100, pulse ext_irq for 1 cycle -> irq[2] rises 4 cycles later (2 sync + edge + output register) and stays high. W1C 0x4 to 0x7F84 -> irq[2] drops; same-cycle re-edge keeps it set.
5. Write IRQ_MASK=6'h3E with dev_irq[0] level high -> irq[0]=0. Read 0x7F84 -> bit0=1.
6. Assert reset while in DEV -> dev_req, cpu_ready and irq go 0 asynchronously; after release the next request completes normally.

Source files
------------

// File: rtl/south_bridge_nx_pkg.sv
// -----------------------------------------------------------------------------
// south_bridge_nx_pkg
// Shared definitions for the south bridge and its interrupt controller:
// bridge FSM state encoding, bridge control-register offsets, default device
// and control window bases, and the width of the CP0 hardware interrupt vector.
// -----------------------------------------------------------------------------
package south_bridge_nx_pkg;

    // Width of the HWInt vector delivered to CP0 (IRQ[7:2]).
    localparam int HWINT_W = 6;

    // Bridge transaction FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEV  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte offsets inside the bridge's own two-word register window.
    localparam logic [2:0] OFF_IRQ_MASK = 3'h0;
    localparam logic [2:0] OFF_IRQ_PEND = 3'h4;

    // Default address map: slot 1 at 0x7F10, slot 0 at 0x7F00.
    localparam logic [63:0] DEF_DEV_BASE  = {32'h0000_7F10, 32'h0000_7F00};
    localparam logic [31:0] DEF_CTRL_BASE = 32'h0000_7F80;

    // Every interrupt line is enabled out of reset.
    localparam logic [HWINT_W-1:0] IRQ_MASK_RST = 6'h3F;

endpackage

// File: rtl/south_bridge_nx_irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl_nx
// Conditions device and external interrupt sources into the registered HWInt
// vector. External lines cross into clk through a 2-flop synchroniser; device
// lines are already synchronous. Each line is either level (pending follows the
// source) or rising-edge latched (pending sticks until a W1C clear).
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   dev_irq        NDEV synchronous device interrupt lines
//   ext_irq        NEXT asynchronous external lines (at least one; tie low
//                  if unused)
//   mask_we        write strobe for the mask register
//   pend_w1c       write-one-to-clear strobe for edge-latched pending bits
//   wr_data        data for mask_we / pend_w1c
//   irq_mask       current mask register
//   irq_pend       current pending vector
//   irq            registered pending & mask
// -----------------------------------------------------------------------------
module irq_ctrl_nx
    import south_bridge_nx_pkg::*;
#(
    parameter int                  NDEV      = 2,
    parameter int                  NEXT      = 1,
    parameter logic [HWINT_W-1:0]  EDGE_MODE = 6'b000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NDEV-1:0]    dev_irq,
    input  logic [NEXT-1:0]    ext_irq,
    input  logic               mask_we,
    input  logic               pend_w1c,
    input  logic [HWINT_W-1:0] wr_data,
    output logic [HWINT_W-1:0] irq_mask,
    output logic [HWINT_W-1:0] irq_pend,
    output logic [HWINT_W-1:0] irq
);

    logic [NEXT-1:0]    ext_s1_reg;
    logic [NEXT-1:0]    ext_s2_reg;
    logic [HWINT_W-1:0] src;
    logic [HWINT_W-1:0] src_prev_reg;
    logic [HWINT_W-1:0] edge_pend_reg;
    logic [HWINT_W-1:0] edge_pend_next;
    logic [HWINT_W-1:0] mask_reg;
    logic [HWINT_W-1:0] irq_reg;

    // Source vector: device lines in the LSBs, synchronised external lines
    // directly above them, unused lines tied low.
    genvar gi;
    generate
        for (gi = 0; gi < HWINT_W; gi++) begin : g_src
            if (gi < NDEV) begin : g_dev
                assign src[gi] = dev_irq[gi];
            end else if (gi < NDEV + NEXT) begin : g_ext
                assign src[gi] = ext_s2_reg[gi-NDEV];
            end else begin : g_zero
                assign src[gi] = 1'b0;
            end
        end
    endgenerate

    // Clear is applied first so a rising edge in the same cycle survives.
    always_comb begin
        edge_pend_next = edge_pend_reg;
        if (pend_w1c) begin
            edge_pend_next = edge_pend_next & ~wr_data;
        end
        edge_pend_next = (edge_pend_next | (src & ~src_prev_reg)) & EDGE_MODE;
    end

    assign irq_pend = (edge_pend_reg & EDGE_MODE) | (src & ~EDGE_MODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_s1_reg    <= '0;
            ext_s2_reg    <= '0;
            src_prev_reg  <= '0;
            edge_pend_reg <= '0;
            mask_reg      <= IRQ_MASK_RST;
            irq_reg       <= '0;
        end else begin
            ext_s1_reg    <= ext_irq;
            ext_s2_reg    <= ext_s1_reg;
            src_prev_reg  <= src;
            edge_pend_reg <= edge_pend_next;
            if (mask_we) begin
                mask_reg <= wr_data;
            end
            irq_reg       <= irq_pend & mask_reg;
        end
    end

    assign irq_mask = mask_reg;
    assign irq      = irq_reg;

endmodule

// File: rtl/south_bridge_nx.sv
// -----------------------------------------------------------------------------
// south_bridge_nx
// Bridges the CPU device-space port to NDEV memory-mapped device slots. Each
// slot owns a 2^(DEV_AW+2)-byte window; the bridge itself owns a two-word
// control window (IRQ mask, IRQ pending). A device access runs a registered
// req/ack handshake with wait states and a timeout that returns a bus error.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cpu_req               request, held until cpu_ready
//   cpu_addr/wdata/we     byte address, write data, byte enables (0 = read)
//   cpu_rdata, cpu_err    response data / bus error, qualified by cpu_ready
//   cpu_ready             one-cycle completion pulse
//   irq                   HWInt[7:2] to CP0
//   dev_req               one-hot request to the selected slot
//   dev_addr/wdata/we     shared word offset, write data, byte enables
//   dev_rdata, dev_ack    packed per-slot read data, per-slot acknowledge
//   dev_irq, ext_irq      device interrupts, asynchronous external interrupts
// -----------------------------------------------------------------------------
module south_bridge_nx
    import south_bridge_nx_pkg::*;
#(
    parameter int                  NDEV      = 2,
    parameter int                  NEXT      = 1,
    parameter logic [NDEV*32-1:0]  DEV_BASE  = DEF_DEV_BASE,
    parameter int                  DEV_AW    = 2,
    parameter logic [31:0]         CTRL_BASE = DEF_CTRL_BASE,
    parameter int                  TIMEOUT   = 15,
    parameter logic [HWINT_W-1:0]  EDGE_MODE = 6'b000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_we,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_err,
    output logic [HWINT_W-1:0]   irq,
    output logic [NDEV-1:0]      dev_req,
    output logic [DEV_AW-1:0]    dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [3:0]           dev_we,
    input  logic [NDEV*32-1:0]   dev_rdata,
    input  logic [NDEV-1:0]      dev_ack,
    input  logic [NDEV-1:0]      dev_irq,
    input  logic [NEXT-1:0]      ext_irq
);

    localparam int TAG_LSB = DEV_AW + 2;
    localparam int IDX_W   = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int WCNT_W  = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic [NDEV-1:0]   dev_req_reg, dev_req_next;
    logic [DEV_AW-1:0] dev_addr_reg, dev_addr_next;
    logic [31:0]       dev_wdata_reg, dev_wdata_next;
    logic [3:0]        dev_we_reg, dev_we_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic [NDEV-1:0]    slot_hit;
    logic               any_hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               ctrl_hit;
    logic [31:0]        slot_rdata [NDEV];
    logic               mask_we, pend_w1c;
    logic [HWINT_W-1:0] irq_mask, irq_pend;

    // Byte-lane bits of the address never affect decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Per-slot window compare and read-data unpacking.
    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_slot
            assign slot_hit[gi]   = (cpu_addr[31:TAG_LSB] == DEV_BASE[32*gi+31 : 32*gi+TAG_LSB]);
            assign slot_rdata[gi] = dev_rdata[32*gi +: 32];
        end
    endgenerate

    // Priority encode: scanning downward leaves the lowest hitting slot.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    assign ctrl_hit = (cpu_addr[31:3] == CTRL_BASE[31:3]);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        wcnt_next      = wcnt_reg;
        dev_req_next   = dev_req_reg;
        dev_addr_next  = dev_addr_reg;
        dev_wdata_next = dev_wdata_reg;
        dev_we_next    = dev_we_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        mask_we        = 1'b0;
        pend_w1c       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (any_hit) begin
                        state_next     = ST_DEV;
                        idx_next       = hit_idx;
                        wcnt_next      = '0;
                        dev_req_next   = NDEV'(1) << hit_idx;
                        dev_addr_next  = cpu_addr[TAG_LSB-1:2];
                        dev_wdata_next = cpu_wdata;
                        dev_we_next    = cpu_we;
                    end else begin
                        // Control registers complete in the request cycle;
                        // anything else is an unmapped access.
                        state_next = ST_RESP;
                        err_next   = !ctrl_hit;
                        rdata_next = '0;
                        if (ctrl_hit) begin
                            if ({cpu_addr[2], 2'b00} == OFF_IRQ_PEND) begin
                                rdata_next = {{(32-HWINT_W){1'b0}}, irq_pend};
                                pend_w1c   = cpu_we[0];
                            end else begin
                                rdata_next = {{(32-HWINT_W){1'b0}}, irq_mask};
                                mask_we    = cpu_we[0];
                            end
                        end
                    end
                end
            end

            ST_DEV: begin
                // An ack in the same cycle the counter reaches TIMEOUT wins.
                if (dev_ack[idx_reg]) begin
                    state_next   = ST_RESP;
                    rdata_next   = slot_rdata[idx_reg];
                    err_next     = 1'b0;
                    dev_req_next = '0;
                end else if (wcnt_reg == WCNT_W'(TIMEOUT)) begin
                    state_next   = ST_RESP;
                    rdata_next   = '0;
                    err_next     = 1'b1;
                    dev_req_next = '0;
                end else if (wcnt_reg != {WCNT_W{1'b1}}) begin
                    wcnt_next = wcnt_reg + 1'b1;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            wcnt_reg      <= '0;
            dev_req_reg   <= '0;
            dev_addr_reg  <= '0;
            dev_wdata_reg <= '0;
            dev_we_reg    <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            wcnt_reg      <= wcnt_next;
            dev_req_reg   <= dev_req_next;
            dev_addr_reg  <= dev_addr_next;
            dev_wdata_reg <= dev_wdata_next;
            dev_we_reg    <= dev_we_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    irq_ctrl_nx #(
        .NDEV      (NDEV),
        .NEXT      (NEXT),
        .EDGE_MODE (EDGE_MODE)
    ) u_irq (
        .clk      (clk),
        .reset    (reset),
        .dev_irq  (dev_irq),
        .ext_irq  (ext_irq),
        .mask_we  (mask_we),
        .pend_w1c (pend_w1c),
        .wr_data  (cpu_wdata[HWINT_W-1:0]),
        .irq_mask (irq_mask),
        .irq_pend (irq_pend),
        .irq      (irq)
    );

    assign cpu_ready = (state_reg == ST_RESP);
    assign cpu_rdata = rdata_reg;
    assign cpu_err   = err_reg;
    assign dev_req   = dev_req_reg;
    assign dev_addr  = dev_addr_reg;
    assign dev_wdata = dev_wdata_reg;
    assign dev_we    = dev_we_reg;

endmodule

// File: tb/tb_south_bridge_nx.sv
// -----------------------------------------------------------------------------
// tb_south_bridge_nx
// Table of CPU accesses with expected response, latency and device-side
// activity; expectations are queued when an access is driven and checked when
// cpu_ready appears. Hand-written sequences cover edge IRQs, masking and reset.
// -----------------------------------------------------------------------------
module tb_south_bridge_nx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [5:0]  irq;
    logic [1:0]  dev_req;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_we;
    logic [63:0] dev_rdata;
    logic [1:0]  dev_ack;
    logic [1:0]  dev_irq;
    logic [0:0]  ext_irq;

    int n_cmp = 0;
    int n_bad = 0;
    int dev_wait = 0;
    int wcnt [2];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        int          wt;
        logic [31:0] dval;
        logic [31:0] exp_rd;
        logic        chk_rd;
        logic        exp_err;
        int          lat;
        logic [1:0]  req;
        int          req_cyc;
        logic [1:0]  daddr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        err;
        int          lat;
        logic [1:0]  req;
        int          req_cyc;
        logic [1:0]  daddr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[15];

    south_bridge_nx #(
        .EDGE_MODE (6'b000100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .irq       (irq),
        .dev_req   (dev_req),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack),
        .dev_irq   (dev_irq),
        .ext_irq   (ext_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Device model: each slot acks once it has seen dev_req for dev_wait
    // extra cycles (dev_wait >= 255 means it never answers).
    initial begin
        dev_ack = 2'b00;
        wcnt[0] = 0;
        wcnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (dev_req[s]) begin
                    dev_ack[s] = (wcnt[s] == dev_wait);
                    wcnt[s]    = wcnt[s] + 1;
                end else begin
                    dev_ack[s] = 1'b0;
                    wcnt[s]    = 0;
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] we, input int wt, input logic [31:0] dval,
                                input logic [31:0] exp_rd, input logic chk_rd,
                                input logic exp_err, input int lat, input logic [1:0] req,
                                input int req_cyc, input logic [1:0] daddr);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.we = we; v.wt = wt; v.dval = dval;
        v.exp_rd = exp_rd; v.chk_rd = chk_rd; v.exp_err = exp_err; v.lat = lat;
        v.req = req; v.req_cyc = req_cyc; v.daddr = daddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after cpu_ready.
    task automatic do_access(input vec_t v, input string tag);
        exp_t        e;
        int          cyc;
        int          req_cyc;
        logic [1:0]  seen_req;
        logic [1:0]  cap_addr;
        logic [3:0]  cap_we;
        logic [31:0] cap_wd;
        bit          got;
        e.rd = v.exp_rd; e.chk_rd = v.chk_rd; e.err = v.exp_err; e.lat = v.lat;
        e.req = v.req; e.req_cyc = v.req_cyc; e.daddr = v.daddr;
        e.we = v.we; e.wdata = v.wdata;
        sb_q.push_back(e);
        dev_wait  = v.wt;
        dev_rdata = {v.dval, ~v.dval};
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_we    = v.we;
        cpu_req   = 1'b1;
        cyc = 0; req_cyc = 0; seen_req = 2'b00; got = 0;
        cap_addr = '0; cap_we = '0; cap_wd = '0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            if (dev_req != 2'b00) begin
                if (seen_req == 2'b00) begin
                    cap_addr = dev_addr;
                    cap_we   = dev_we;
                    cap_wd   = dev_wdata;
                end
                seen_req = seen_req | dev_req;
                req_cyc++;
            end
            if (cpu_ready) begin
                got = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ready: no cpu_ready within 64 cycles, want latency %0d", tag, e.lat);
        end else begin
            $display("access %s addr=%08h we=%h rdata=%08h err=%0b lat=%0d req=%b x%0d",
                     tag, v.addr, v.we, cpu_rdata, cpu_err, cyc, seen_req, req_cyc);
            if (e.chk_rd) chk({tag, "_rdata"}, cpu_rdata, e.rd);
            chk({tag, "_err"}, 32'(cpu_err), 32'(e.err));
            chk({tag, "_lat"}, cyc, e.lat);
            chk({tag, "_devreq"}, 32'(seen_req), 32'(e.req));
            chk({tag, "_reqcyc"}, req_cyc, e.req_cyc);
            if (e.req_cyc > 0) begin
                chk({tag, "_daddr"}, 32'(cap_addr), 32'(e.daddr));
                chk({tag, "_dwe"}, 32'(cap_we), 32'(e.we));
                chk({tag, "_dwdata"}, cap_wd, e.wdata);
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 4'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               addr          wdata         we    wt   dval          exp_rd       chk err lat req   rc  da
        tbl[0]  = mk(32'h0000_7F14, 32'h0,         4'h0,   3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0,  5, 2'b10, 4, 2'd1);
        tbl[1]  = mk(32'h0000_7F00, 32'h12345678, 4'hF,   0, 32'h0,        32'hFFFFFFFF, 1, 0,  2, 2'b01, 1, 2'd0);
        tbl[2]  = mk(32'h0000_7F40, 32'h0,         4'h0,   0, 32'h0,        32'h0,        0, 1,  1, 2'b00, 0, 2'd0);
        tbl[3]  = mk(32'h0000_7F08, 32'h0,         4'h0, 255, 32'h0,        32'h0,        1, 1, 17, 2'b01, 16, 2'd2);
        tbl[4]  = mk(32'h0000_7F1C, 32'h0,         4'h0,  15, 32'hCAFE0001, 32'hCAFE0001, 1, 0, 17, 2'b10, 16, 2'd3);
        tbl[5]  = mk(32'h0000_7F80, 32'h0,         4'h0,   0, 32'h0,        32'h3F,       1, 0,  1, 2'b00, 0, 2'd0);
        tbl[6]  = mk(32'h0000_7F80, 32'hFFFFFF2A, 4'h1,   0, 32'h0,        32'h0,        0, 0,  1, 2'b00, 0, 2'd0);
        tbl[7]  = mk(32'h0000_7F80, 32'h0,         4'h0,   0, 32'h0,        32'h2A,       1, 0,  1, 2'b00, 0, 2'd0);
        tbl[8]  = mk(32'h0000_7F80, 32'h00000015, 4'h2,   0, 32'h0,        32'h0,        0, 0,  1, 2'b00, 0, 2'd0);
        tbl[9]  = mk(32'h0000_7F80, 32'h0,         4'h0,   0, 32'h0,        32'h2A,       1, 0,  1, 2'b00, 0, 2'd0);
        tbl[10] = mk(32'h0000_7F80, 32'h0000003F, 4'h1,   0, 32'h0,        32'h0,        0, 0,  1, 2'b00, 0, 2'd0);
        tbl[11] = mk(32'h0000_7F84, 32'h0,         4'h0,   0, 32'h0,        32'h0,        1, 0,  1, 2'b00, 0, 2'd0);
        tbl[12] = mk(32'h0000_7F88, 32'h0,         4'h0,   0, 32'h0,        32'h0,        0, 1,  1, 2'b00, 0, 2'd0);
        tbl[13] = mk(32'h0000_7F10, 32'h0,         4'h0,   0, 32'h00000001, 32'h00000001, 1, 0,  2, 2'b10, 1, 2'd0);
        tbl[14] = mk(32'h0000_7F04, 32'hA5A55A5A, 4'h3,   1, 32'h00000077, 32'hFFFFFF88, 1, 0,  3, 2'b01, 2, 2'd1);

        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = '0;
        dev_rdata = '0; dev_irq = 2'b00; ext_irq = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(cpu_ready), 32'h0);
        chk("rst_err", 32'(cpu_err), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_devreq", 32'(dev_req), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #2 reset = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            do_access(tbl[i], $sformatf("v%0d", i));
        end

        // Edge-latched external line (HWInt bit 2).
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        step();
        step();
        @(negedge clk) chk("edge_c3", 32'(irq), 32'h0);
        step();
        @(negedge clk) chk("edge_c4", 32'(irq), 32'h4);
        repeat (3) step();
        @(negedge clk) chk("edge_hold", 32'(irq), 32'h4);
        step();
        do_access(mk(32'h7F84, 32'h4, 4'h1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), "w1c");
        @(negedge clk) chk("w1c_clear", 32'(irq), 32'h0);
        step();
        // Rising edge reaches the detector in the same cycle as the clear.
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        step();
        do_access(mk(32'h7F84, 32'h4, 4'h1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), "w1c_race");
        @(negedge clk) chk("w1c_race_set", 32'(irq), 32'h4);
        step();
        do_access(mk(32'h7F84, 32'h4, 4'h1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), "w1c2");
        @(negedge clk) chk("w1c2_clear", 32'(irq), 32'h0);
        step();

        // Masked level line.
        do_access(mk(32'h7F80, 32'h3E, 4'h1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), "mask3e");
        dev_irq = 2'b01;
        step();
        step();
        @(negedge clk) chk("mask_irq0", 32'(irq), 32'h0);
        step();
        do_access(mk(32'h7F84, 0, 4'h0, 0, 0, 32'h1, 1, 0, 1, 2'b00, 0, 0), "pend_rd");
        dev_irq = 2'b11;
        step();
        @(negedge clk) chk("level_irq1", 32'(irq), 32'h2);
        step();

        // Reset in the middle of a device access.
        dev_wait  = 255;
        cpu_addr  = 32'h7F00;
        cpu_we    = 4'h0;
        cpu_req   = 1'b1;
        step();
        step();
        @(negedge clk) chk("pre_rst_devreq", 32'(dev_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_devreq", 32'(dev_req), 32'h0);
        chk("async_ready", 32'(cpu_ready), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        cpu_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_ready%0d", k), 32'(cpu_ready), 32'h0);
            chk($sformatf("post_rst_devreq%0d", k), 32'(dev_req), 32'h0);
            step();
        end
        @(negedge clk) chk("post_rst_irq", 32'(irq), 32'h3);
        step();
        do_access(tbl[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
